acc_cpu_param: RTL and testbench
================================

Name: acc_cpu_param

Overview:
- Parametrised accumulator CPU with single-issue instruction FSM, generic data width and memory depth, and a valid/ready instruction handshake.
- Adds LOAD-immediate, memory-operand ADD, CLR, and zero/carry flags.
- Adds a one-cycle result strobe.
- Sits between the top-level pin wrapper (instruction source) and output pins/display logic.

Parameters:
- DATA_W, 8, width of accumulator, memory words, in_data and out_acc (legal 4..16).
- ADDR_W, 4, memory address width; memory depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; low blocks new instruction acceptance.
- in_valid  input  1  instruction present on in_opcode/in_addr/in_data.
- in_ready  output  1  block can accept an instruction this cycle.
- in_opcode  input  4  operation code.
- in_addr  input  ADDR_W  memory address operand.
- in_data  input  DATA_W  immediate operand.
- out_acc  output  DATA_W  current accumulator value, registered.
- out_valid  output  1  one-cycle pulse when an instruction retires.
- flag_zero  output  1  accumulator == 0 after last acc-writing op.
- flag_carry  output  1  carry/borrow/shifted-out bit of last arithmetic or shift op.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset:
  - Asynchronous active-low reset; all state clears immediately on rst_n low.
  - out_acc=0, flag_zero=1, flag_carry=0, out_valid=0, busy=0, FSM=IDLE.
  - All 2**ADDR_W memory words = 0.
  - After reset release, in_ready follows ena.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: in_ready = ena. On a clock edge with in_valid & in_ready, latch opcode/addr/data into the instruction register, go to EXEC.
  - EXEC:
    - Read memory[addr] combinationally.
    - Compute result; on the edge, update acc/flags/memory per opcode.
    - Go to RESP.
  - RESP: out_valid=1 for exactly this cycle; next state IDLE.
- Latency and throughput:
  - Acceptance at edge N; accumulator valid at edge N+1; out_valid high during cycle N+1 to N+2.
  - Throughput is one instruction per 3 cycles.
  - in_ready=0 in EXEC and RESP.
  - in_valid held across busy cycles is not re-accepted until IDLE.
- Opcodes (a = acc, d = in_data, m = memory[addr]), all results truncated to DATA_W:
  - 0 ADD: a+d, carry = bit DATA_W.
  - 1 SUB: a-d, carry = borrow (1 when d>a).
  - 2 STORE: memory[addr] <= a; acc and flags unchanged.
  - 3 LOAD: a <= m.
  - 4 LDI: a <= d.
  - 5 AND: a&d.
  - 6 OR: a|d.
  - 7 XOR: a^d.
  - 8 NOT: ~a.
  - 9 SHL: a<<1, carry = old MSB.
  - A SHR: a>>1 logical, carry = old LSB.
  - B ADDM: a+m, carry = bit DATA_W.
  - C CLR: a <= 0.
  - D-F NOP: still retires with out_valid; no state change.
- Flag rules:
  - flag_zero updates on every opcode that writes acc (0,1,3-C).
  - flag_carry updates only on 0,1,9,A,B; it holds otherwise.
- ena behaviour:
  - ena low in IDLE: no acceptance.
  - ena dropping in EXEC/RESP does not abort; the instruction retires normally.
- Memory hazard: a STORE followed by a LOAD of the same address returns the stored value (write completes at EXEC edge before the next acceptance).
- Wrap-around: arithmetic overflow wraps modulo 2**DATA_W; no saturation.
- Reset mid-operation: in-flight instruction is discarded, out_valid is not emitted, and memory is cleared.

Decomposition:
- Package acc_cpu_pkg: opcode localparams OP_ADD..OP_CLR, FSM state encoding (2-bit: IDLE=0, EXEC=1, RESP=2).
- One combinational sub-module acc_cpu_alu:
  - Parameter DATA_W.
  - Inputs: opcode, a, d, m, carry_in.
  - Outputs: result, carry_out, writes_acc, writes_carry.
- FSM, instruction register and memory stay in acc_cpu_param.

Test Plan (DATA_W=8, ADDR_W=4):
- Reset then idle -> out_acc=0x00, flag_zero=1, flag_carry=0, in_ready=ena; LOAD of every address 0..15 returns 0x00.
- LDI 0xF0, ADD 0x20 -> out_acc=0x10, flag_carry=1, flag_zero=0; out_valid pulses exactly once per instruction, 1 cycle after acceptance.
- LDI 0x05, SUB 0x05 -> 0x00, zero=1, carry=0; then SUB 0x01 -> 0xFF, carry=1 (borrow).
- LDI 0x3C, STORE addr 15, CLR, LOAD addr 15 -> 0x3C; then ADDM addr 15 -> 0x78; then SHL -> 0xF0, carry=0; then SHL -> 0xE0, carry=1.
- Hold in_valid high continuously with ena toggling -> accept only in IDLE with ena=1; count accepted instructions == count of out_valid pulses; in_ready=0 in EXEC/RESP.
- Assert rst_n low during EXEC of ADD 0x01 with acc=0x7F -> out_acc=0x00 immediately, no out_valid; memory cleared; next instruction executes normally.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode values and FSM state encoding.
package acc_cpu_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_LOAD  = 4'h3;
   localparam logic [3:0] OP_LDI   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_NOT   = 4'h8;
   localparam logic [3:0] OP_SHL   = 4'h9;
   localparam logic [3:0] OP_SHR   = 4'hA;
   localparam logic [3:0] OP_ADDM  = 4'hB;
   localparam logic [3:0] OP_CLR   = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU: result, carry and which of acc/carry the opcode writes.
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] d,
   input  logic [DATA_W-1:0] m,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              writes_acc,
   output logic              writes_carry
);

   logic [DATA_W:0] wide_s;

   // Opcode decode; the extra top bit of wide_s is the carry (or borrow for SUB).
   always_comb begin
      result       = a;
      carry_out    = carry_in;
      writes_acc   = 1'b0;
      writes_carry = 1'b0;
      wide_s       = '0;
      case (opcode)
         OP_ADD: begin
            wide_s       = {1'b0, a} + {1'b0, d};
            result       = wide_s[DATA_W-1:0];
            carry_out    = wide_s[DATA_W];
            writes_acc   = 1'b1;
            writes_carry = 1'b1;
         end
         OP_SUB: begin
            wide_s       = {1'b0, a} - {1'b0, d};
            result       = wide_s[DATA_W-1:0];
            carry_out    = wide_s[DATA_W];
            writes_acc   = 1'b1;
            writes_carry = 1'b1;
         end
         OP_LOAD: begin
            result     = m;
            writes_acc = 1'b1;
         end
         OP_LDI: begin
            result     = d;
            writes_acc = 1'b1;
         end
         OP_AND: begin
            result     = a & d;
            writes_acc = 1'b1;
         end
         OP_OR: begin
            result     = a | d;
            writes_acc = 1'b1;
         end
         OP_XOR: begin
            result     = a ^ d;
            writes_acc = 1'b1;
         end
         OP_NOT: begin
            result     = ~a;
            writes_acc = 1'b1;
         end
         OP_SHL: begin
            result       = {a[DATA_W-2:0], 1'b0};
            carry_out    = a[DATA_W-1];
            writes_acc   = 1'b1;
            writes_carry = 1'b1;
         end
         OP_SHR: begin
            result       = {1'b0, a[DATA_W-1:1]};
            carry_out    = a[0];
            writes_acc   = 1'b1;
            writes_carry = 1'b1;
         end
         OP_ADDM: begin
            wide_s       = {1'b0, a} + {1'b0, m};
            result       = wide_s[DATA_W-1:0];
            carry_out    = wide_s[DATA_W];
            writes_acc   = 1'b1;
            writes_carry = 1'b1;
         end
         OP_CLR: begin
            result     = '0;
            writes_acc = 1'b1;
         end
         default: begin
            result       = a;
            carry_out    = carry_in;
            writes_acc   = 1'b0;
            writes_carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: IDLE/EXEC/RESP instruction FSM, instruction register,
// data memory and flags, with a valid/ready instruction input and a one-cycle retire strobe.
module acc_cpu_param
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_acc,
   output logic              out_valid,
   output logic              flag_zero,
   output logic              flag_carry,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_e              state_q, state_d;
   logic [3:0]          ir_op_q, ir_op_d;
   logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
   logic [DATA_W-1:0]   ir_data_q, ir_data_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic                zero_q, zero_d;
   logic                carry_q, carry_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                mem_we_s;
   logic                in_ready_s;

   logic [DATA_W-1:0]   alu_result_s;
   logic                alu_carry_s;
   logic                alu_wr_acc_s;
   logic                alu_wr_carry_s;

   acc_cpu_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .opcode       (ir_op_q),
      .a            (acc_q),
      .d            (ir_data_q),
      .m            (mem_q[ir_addr_q]),
      .carry_in     (carry_q),
      .result       (alu_result_s),
      .carry_out    (alu_carry_s),
      .writes_acc   (alu_wr_acc_s),
      .writes_carry (alu_wr_carry_s)
   );

   // Next-state, instruction latch and architectural updates.
   always_comb begin
      state_d     = state_q;
      ir_op_d     = ir_op_q;
      ir_addr_d   = ir_addr_q;
      ir_data_d   = ir_data_q;
      acc_d       = acc_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      out_valid_d = 1'b0;
      mem_we_s    = 1'b0;
      in_ready_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_s = ena;
            if (in_valid && ena) begin
               ir_op_d   = in_opcode;
               ir_addr_d = in_addr;
               ir_data_d = in_data;
               state_d   = ST_EXEC;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (alu_wr_acc_s) begin
               acc_d  = alu_result_s;
               zero_d = (alu_result_s == '0);
            end else begin
               acc_d  = acc_q;
               zero_d = zero_q;
            end
            if (alu_wr_carry_s) begin
               carry_d = alu_carry_s;
            end else begin
               carry_d = carry_q;
            end
            if (ir_op_q == OP_STORE) begin
               mem_we_s = 1'b1;
            end else begin
               mem_we_s = 1'b0;
            end
            out_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Control, instruction and architectural state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ir_op_q     <= 4'h0;
         ir_addr_q   <= '0;
         ir_data_q   <= '0;
         acc_q       <= '0;
         zero_q      <= 1'b1;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_op_q     <= ir_op_d;
         ir_addr_q   <= ir_addr_d;
         ir_data_q   <= ir_data_d;
         acc_q       <= acc_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Data memory; cleared by reset so a reset mid-instruction leaves no stale words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we_s) begin
         mem_q[ir_addr_q] <= acc_q;
      end
   end

   assign in_ready   = in_ready_s;
   assign out_acc    = acc_q;
   assign out_valid  = out_valid_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed self-checking bench for acc_cpu_param (DATA_W=8, ADDR_W=4).
module tb_acc_cpu_param;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_LOAD  = 4'h3;
   localparam logic [3:0] OP_LDI   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_NOT   = 4'h8;
   localparam logic [3:0] OP_SHL   = 4'h9;
   localparam logic [3:0] OP_SHR   = 4'hA;
   localparam logic [3:0] OP_ADDM  = 4'hB;
   localparam logic [3:0] OP_CLR   = 4'hC;
   localparam logic [3:0] OP_NOP   = 4'hE;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_opcode;
   logic [3:0] in_addr;
   logic [7:0] in_data;
   logic [7:0] out_acc;
   logic       out_valid;
   logic       flag_zero;
   logic       flag_carry;
   logic       busy;

   int tests  = 0;
   int failed = 0;

   acc_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .out_acc    (out_acc),
      .out_valid  (out_valid),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [7:0] acc, input logic z, input logic c);
      chk({tag, "_acc"}, out_acc, acc);
      chk({tag, "_zero"}, flag_zero, z);
      chk({tag, "_carry"}, flag_carry, c);
   endtask

   // Issue one instruction and check the handshake and the single retire pulse.
   task automatic do_instr(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] data,
                           input string tag);
      int waited;
      @(negedge clk);
      in_valid  = 1'b1;
      in_opcode = op;
      in_addr   = addr;
      in_data   = data;
      #1;
      waited = 0;
      while (in_ready !== 1'b1 && waited < 10) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk({tag, "_ready"}, in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_exec_ov"}, out_valid, 1'b0);
      chk({tag, "_exec_rdy"}, in_ready, 1'b0);
      @(negedge clk);
      chk({tag, "_resp_ov"}, out_valid, 1'b1);
      chk({tag, "_resp_rdy"}, in_ready, 1'b0);
      @(negedge clk);
      chk({tag, "_after_ov"}, out_valid, 1'b0);
      chk({tag, "_after_busy"}, busy, 1'b0);
   endtask

   initial begin
      logic [39:0] pat;
      int          m_st;
      int          accepted;
      int          pulses;
      logic        iv;
      logic        exp_rdy;

      rst_n     = 1'b0;
      ena       = 1'b0;
      in_valid  = 1'b0;
      in_opcode = 4'h0;
      in_addr   = 4'h0;
      in_data   = 8'h00;
      repeat (3) @(negedge clk);
      chk_state("rst", 8'h00, 1'b1, 1'b0);
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_rdy_ena0", in_ready, 1'b0);
      ena = 1'b1;
      #1;
      chk("idle_rdy_ena1", in_ready, 1'b1);

      for (int a = 0; a < 16; a++) begin
         do_instr(OP_LDI, 4'h0, 8'hAA, "pre_ldi");
         do_instr(OP_LOAD, a[3:0], 8'h00, "load_rst");
         chk_state("load_rst", 8'h00, 1'b1, 1'b0);
      end

      do_instr(OP_LDI, 4'h0, 8'hF0, "ldi_f0");
      chk_state("ldi_f0", 8'hF0, 1'b0, 1'b0);
      do_instr(OP_ADD, 4'h0, 8'h20, "add_20");
      chk_state("add_20", 8'h10, 1'b0, 1'b1);

      do_instr(OP_LDI, 4'h0, 8'h05, "ldi_05");
      chk_state("ldi_05", 8'h05, 1'b0, 1'b1);
      do_instr(OP_SUB, 4'h0, 8'h05, "sub_05");
      chk_state("sub_05", 8'h00, 1'b1, 1'b0);
      do_instr(OP_SUB, 4'h0, 8'h01, "sub_01");
      chk_state("sub_01", 8'hFF, 1'b0, 1'b1);

      do_instr(OP_LDI, 4'h0, 8'h3C, "ldi_3c");
      do_instr(OP_STORE, 4'hF, 8'h00, "store_15");
      chk_state("store_15", 8'h3C, 1'b0, 1'b1);
      do_instr(OP_CLR, 4'h0, 8'h00, "clr");
      chk_state("clr", 8'h00, 1'b1, 1'b1);
      do_instr(OP_LOAD, 4'hF, 8'h00, "load_15");
      chk_state("load_15", 8'h3C, 1'b0, 1'b1);
      do_instr(OP_ADDM, 4'hF, 8'h00, "addm_15");
      chk_state("addm_15", 8'h78, 1'b0, 1'b0);
      do_instr(OP_SHL, 4'h0, 8'h00, "shl_1");
      chk_state("shl_1", 8'hF0, 1'b0, 1'b0);
      do_instr(OP_SHL, 4'h0, 8'h00, "shl_2");
      chk_state("shl_2", 8'hE0, 1'b0, 1'b1);

      do_instr(OP_LDI, 4'h0, 8'hA5, "ldi_a5");
      do_instr(OP_AND, 4'h0, 8'h0F, "and");
      chk_state("and", 8'h05, 1'b0, 1'b1);
      do_instr(OP_OR, 4'h0, 8'h30, "or");
      chk_state("or", 8'h35, 1'b0, 1'b1);
      do_instr(OP_XOR, 4'h0, 8'hFF, "xor");
      chk_state("xor", 8'hCA, 1'b0, 1'b1);
      do_instr(OP_NOT, 4'h0, 8'h00, "not");
      chk_state("not", 8'h35, 1'b0, 1'b1);
      do_instr(OP_SHR, 4'h0, 8'h00, "shr");
      chk_state("shr", 8'h1A, 1'b0, 1'b1);
      do_instr(OP_NOP, 4'h0, 8'hFF, "nop");
      chk_state("nop", 8'h1A, 1'b0, 1'b1);
      do_instr(OP_LDI, 4'h0, 8'hFF, "ldi_ff");
      do_instr(OP_ADD, 4'h0, 8'h01, "add_wrap");
      chk_state("add_wrap", 8'h00, 1'b1, 1'b1);

      // in_valid held high while ena toggles; bench models the FSM independently.
      do_instr(OP_CLR, 4'h0, 8'h00, "hold_clr");
      pat      = 40'hF35AC70EB9;
      m_st     = 0;
      accepted = 0;
      pulses   = 0;
      for (int i = 0; i < 44; i++) begin
         @(negedge clk);
         iv        = (i < 40);
         ena       = iv ? pat[i] : 1'b1;
         in_valid  = iv;
         in_opcode = OP_ADD;
         in_data   = 8'h01;
         #1;
         exp_rdy = (m_st == 0) && ena;
         chk("hold_ready", in_ready, exp_rdy);
         chk("hold_busy", busy, (m_st != 0));
         chk("hold_ov", out_valid, (m_st == 2));
         if (out_valid === 1'b1) pulses++;
         @(posedge clk);
         if (m_st == 0) begin
            if (exp_rdy && iv) begin
               accepted++;
               m_st = 1;
            end
         end else if (m_st == 1) begin
            m_st = 2;
         end else begin
            m_st = 0;
         end
      end
      in_valid = 1'b0;
      ena      = 1'b1;
      chk("hold_pulses", pulses, accepted);
      chk("hold_acc", out_acc, accepted[7:0]);

      // Reset during EXEC of ADD 0x01 with acc=0x7F.
      do_instr(OP_LDI, 4'h0, 8'h7F, "r_ldi");
      do_instr(OP_STORE, 4'h3, 8'h00, "r_store");
      @(negedge clk);
      in_valid  = 1'b1;
      in_opcode = OP_ADD;
      in_addr   = 4'h0;
      in_data   = 8'h01;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("r_exec_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_state("r_mid", 8'h00, 1'b1, 1'b0);
      chk("r_mid_busy", busy, 1'b0);
      chk("r_mid_ov", out_valid, 1'b0);
      @(negedge clk);
      chk("r_hold_ov", out_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("r_rel_ov", out_valid, 1'b0);
      chk("r_rel_acc", out_acc, 8'h00);
      do_instr(OP_LDI, 4'h0, 8'h11, "r_ldi2");
      do_instr(OP_LOAD, 4'h3, 8'h00, "r_load3");
      chk_state("r_load3", 8'h00, 1'b1, 1'b0);
      do_instr(OP_ADD, 4'h0, 8'h01, "r_add");
      chk_state("r_add", 8'h01, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
